// File: rtl/trs_cmd_pkg.sv
// Shared definitions for the TRS-80 /CMD load-module format, used by both the
// image writer and the program loader.
//   CMD_BLK_LOAD  record type of a load block (type byte, length, address, data)
//   CMD_BLK_XFER  record type of the transfer (entry address) block
//   CMD_XFER_LEN  length byte of the transfer block
//   cmd_state_t   encoder FSM states
//   cmd_len_byte  length byte of a load block carrying n data bytes
package trs_cmd_pkg;

  localparam logic [7:0] CMD_BLK_LOAD = 8'h01;
  localparam logic [7:0] CMD_BLK_XFER = 8'h02;
  localparam logic [7:0] CMD_XFER_LEN = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B_TYPE,
    ST_B_LEN,
    ST_B_ALO,
    ST_B_AHI,
    ST_FETCH,
    ST_WAIT,
    ST_B_DATA,
    ST_X_TYPE,
    ST_X_LEN,
    ST_X_ALO,
    ST_X_AHI,
    ST_DONE
  } cmd_state_t;

  // The length byte counts the two address bytes as well and wraps modulo
  // 256, so a full 256-byte block is encoded as 0x02 and 254 bytes as 0x00.
  // Only the low 8 bits of n matter for that.
  function automatic logic [7:0] cmd_len_byte(input logic [7:0] n_lo);
    return n_lo + 8'd2;
  endfunction

endpackage

// File: rtl/cmd_image_writer.sv
// Encodes a RAM range as a TRS-80 /CMD image byte stream: one or more type-01
// load blocks followed by a type-02 transfer block carrying the entry address.
// Ports:
//   clk_sys, reset          system clock, asynchronous active-low reset
//   start                   1-cycle pulse, latches the addresses (ignored while busy)
//   start_addr, end_addr    inclusive RAM range to save
//   entry_addr              execution address for the transfer block
//   mem_addr, mem_rd        RAM read port, read strobe one cycle wide
//   mem_data                RAM data, valid MEM_LAT cycles after mem_rd
//   out_data, out_valid,    image byte stream, valid/ready handshake;
//   out_ready               out_data held stable until accepted
//   out_offset              file offset of the byte currently presented
//   busy, done, err         status; done pulses at the end, err when end < start
module cmd_image_writer
  import trs_cmd_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int BLOCK_MAX = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] entry_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_offset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] BLK_MAX17 = 17'(BLOCK_MAX);

  cmd_state_t state, state_nxt;

  // cur is 17 bits so that stepping past FFFF lands on 10000, which compares
  // greater than any end address and terminates the image without re-reading.
  logic [16:0]        cur;
  logic [15:0]        end_a;
  logic [15:0]        entry_a;
  logic [8:0]         blk_left;
  logic [23:0]        offset;
  logic               err_r;
  logic [MEM_LAT-1:0] rd_vld_p;
  logic [7:0]         data_p1;

  logic [16:0] remain;
  logic [8:0]  n_blk;
  logic        more_data;
  logic        accept;

  always_comb begin
    remain    = {1'b0, end_a} + 17'd1 - cur;
    n_blk     = (remain > BLK_MAX17) ? 9'(BLOCK_MAX) : remain[8:0];
    more_data = (cur + 17'd1) <= {1'b0, end_a};
  end

  assign accept = out_valid & out_ready;

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (start) state_nxt = (end_addr < start_addr) ? ST_DONE : ST_B_TYPE;
      ST_B_TYPE: if (accept) state_nxt = ST_B_LEN;
      ST_B_LEN:  if (accept) state_nxt = ST_B_ALO;
      ST_B_ALO:  if (accept) state_nxt = ST_B_AHI;
      ST_B_AHI:  if (accept) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_WAIT;
      ST_WAIT:   if (rd_vld_p[MEM_LAT-1]) state_nxt = ST_B_DATA;
      ST_B_DATA:
        if (accept) begin
          if (blk_left != 9'd1) state_nxt = ST_FETCH;
          else                  state_nxt = more_data ? ST_B_TYPE : ST_X_TYPE;
        end
      ST_X_TYPE: if (accept) state_nxt = ST_X_LEN;
      ST_X_LEN:  if (accept) state_nxt = ST_X_ALO;
      ST_X_ALO:  if (accept) state_nxt = ST_X_AHI;
      ST_X_AHI:  if (accept) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Byte presented in each emitting state
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state)
      ST_B_TYPE: begin out_valid = 1'b1; out_data = CMD_BLK_LOAD;              end
      ST_B_LEN:  begin out_valid = 1'b1; out_data = cmd_len_byte(n_blk[7:0]);  end
      ST_B_ALO:  begin out_valid = 1'b1; out_data = cur[7:0];                  end
      ST_B_AHI:  begin out_valid = 1'b1; out_data = cur[15:8];                 end
      ST_B_DATA: begin out_valid = 1'b1; out_data = data_p1;                   end
      ST_X_TYPE: begin out_valid = 1'b1; out_data = CMD_BLK_XFER;              end
      ST_X_LEN:  begin out_valid = 1'b1; out_data = CMD_XFER_LEN;              end
      ST_X_ALO:  begin out_valid = 1'b1; out_data = entry_a[7:0];              end
      ST_X_AHI:  begin out_valid = 1'b1; out_data = entry_a[15:8];             end
      default:   ;
    endcase
  end

  assign mem_rd     = (state == ST_FETCH);
  assign mem_addr   = cur[15:0];
  assign out_offset = offset;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign err        = err_r;

  // Control registers
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cur      <= '0;
      blk_left <= '0;
      offset   <= '0;
      err_r    <= 1'b0;
      rd_vld_p <= '0;
    end else begin
      state    <= state_nxt;
      rd_vld_p <= (rd_vld_p << 1) | MEM_LAT'(mem_rd);
      if (state == ST_IDLE && start) begin
        cur    <= {1'b0, start_addr};
        err_r  <= (end_addr < start_addr);
        offset <= '0;
      end
      if (accept) offset <= offset + 24'd1;
      if (state == ST_B_AHI && accept) blk_left <= n_blk;
      if (state == ST_B_DATA && accept) begin
        cur      <= cur + 17'd1;
        blk_left <= blk_left - 9'd1;
      end
    end
  end

  // Read data capture, MEM_LAT cycles after the strobe
  always_ff @(posedge clk_sys) begin
    if (state == ST_IDLE && start) begin
      end_a   <= end_addr;
      entry_a <= entry_addr;
    end
    if (state == ST_WAIT && rd_vld_p[MEM_LAT-1]) data_p1 <= mem_data;
  end

endmodule

// File: tb/tb_cmd_image_writer.sv
// Scoreboard bench for cmd_image_writer: the reference model expands each
// requested range into the expected /CMD byte stream (with file offsets), and a
// monitor pops and compares every accepted byte.
module tb_cmd_image_writer;

  localparam int LAT  = 2;
  localparam int BMAX = 256;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [15:0] entry_addr = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_offset;
  logic        busy, done, err;

  always #5 clk_sys = ~clk_sys;

  cmd_image_writer #(.MEM_LAT(LAT), .BLOCK_MAX(BMAX)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start),
    .start_addr(start_addr), .end_addr(end_addr), .entry_addr(entry_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_offset(out_offset), .busy(busy), .done(done), .err(err)
  );

  // RAM with LAT-cycle read latency; data outside the valid cycle is junk
  logic [7:0]     ram [0:65535];
  logic [7:0]     dpipe [LAT];
  logic [LAT-1:0] vpipe = '0;
  logic [7:0]     junk = 8'h00;

  always @(posedge clk_sys) begin
    dpipe[0] <= ram[mem_addr];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    vpipe <= (vpipe << 1) | LAT'(mem_rd);
    junk  <= 8'($urandom);
  end
  assign mem_data = vpipe[LAT-1] ? dpipe[LAT-1] : junk;

  // Consumer back-pressure
  bit rdy_random = 1'b0;
  initial forever begin
    @(posedge clk_sys);
    #1 out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard
  typedef struct {
    logic [7:0] d;
    int         off;
  } exp_t;
  exp_t exp_q[$];
  int   exp_off;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input int d);
    exp_q.push_back('{d: 8'(d), off: exp_off});
    exp_off++;
  endfunction

  // Reference model: split [s..e] into blocks of at most BMAX bytes
  function automatic void build_expected(input int s, input int e, input int entry);
    int a, n;
    exp_q.delete();
    exp_off = 0;
    if (e < s) return;
    a = s;
    while (a <= e) begin
      n = e - a + 1;
      if (n > BMAX) n = BMAX;
      push(1);
      push((n + 2) % 256);
      push(a % 256);
      push(a / 256);
      for (int k = 0; k < n; k++) push(int'(ram[16'(a + k)]));
      a += n;
    end
    push(2);
    push(2);
    push(entry % 256);
    push(entry / 256);
  endfunction

  // Monitor
  bit         stalled = 1'b0;
  logic [7:0] st_data;
  logic [23:0] st_off;
  initial forever begin
    exp_t e;
    @(negedge clk_sys);
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("valid_held", 32'(out_valid), 32'd1);
        if (out_valid) begin
          chk("stall_data", 32'(out_data), 32'(st_data));
          chk("stall_offset", 32'(out_offset), 32'(st_off));
        end
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %0h at offset %0d, expected no byte", out_data, out_offset);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(out_data), 32'(e.d));
            chk("offset", 32'(out_offset), 32'(e.off));
          end
        end else begin
          stalled = 1'b1;
          st_data = out_data;
          st_off  = out_offset;
        end
      end
    end
  end

  task automatic pulse_start(input int s, input int e, input int entry);
    @(negedge clk_sys);
    start_addr = 16'(s);
    end_addr   = 16'(e);
    entry_addr = 16'(entry);
    start      = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic run_image(input int s, input int e, input int entry, input bit rnd);
    int  total, cyc, budget;
    bit  got;
    build_expected(s, e, entry);
    total      = exp_q.size();
    budget     = total * (LAT + 4) * 3 + 50;
    rdy_random = rnd;
    pulse_start(s, e, entry);
    if (e >= s) chk("busy_after_start", 32'(busy), 32'd1);
    got = 1'b0;
    cyc = 1;
    while (!got && cyc <= budget) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk_sys);
        cyc++;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done after %0d cycles, expected done", budget);
    end else begin
      chk("err_at_done", 32'(err), 32'(e < s));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("bytes_left", 32'(exp_q.size()), 32'd0);
      chk("final_offset", 32'(out_offset), 32'(total));
      if (e < s) chk("err_done_latency", 32'(cyc <= 3), 32'd1);
    end
    exp_q.delete();
    @(negedge clk_sys);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_data"},   32'(out_data),   32'd0);
    chk({tag, "_offset"}, 32'(out_offset), 32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_done"},   32'(done),       32'd0);
    chk({tag, "_err"},    32'(err),        32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd),     32'd0);
    chk({tag, "_addr"},   32'(mem_addr),   32'd0);
  endtask

  task automatic reset_mid_image();
    int  cyc;
    bit  hit;
    build_expected(16'h5000, 16'h5013, 16'h5000);
    rdy_random = 1'b0;
    pulse_start(16'h5000, 16'h5013, 16'h5000);
    // A second start while busy must not disturb the stream
    pulse_start(16'h1234, 16'h1300, 16'h1234);
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 500) begin
      if (out_offset == 24'd10) hit = 1'b1;
      else begin
        @(negedge clk_sys);
        cyc++;
      end
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL offset10_timeout: offset %0d, expected 10", out_offset);
    end
    #2 reset = 1'b0;
    #1 check_idle_outputs("reset_mid");
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("no_done_in_reset", 32'(done), 32'd0);
    end
    reset = 1'b1;
    run_image(16'h5000, 16'h5013, 16'h5000, 1'b0);
  endtask

  initial begin
    int s, len, e;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h5000] = 8'hAA;

    repeat (3) @(negedge clk_sys);
    check_idle_outputs("reset");
    reset = 1'b1;

    run_image(16'h5000, 16'h5000, 16'h5000, 1'b0);
    run_image(16'h6000, 16'h60FF, 16'h6000, 1'b0);
    run_image(16'h7000, 16'h7100, 16'h7123, 1'b0);
    run_image(16'h7000, 16'h7100, 16'h7123, 1'b1);
    run_image(16'h8000, 16'h80FD, 16'h8000, 1'b1);
    run_image(16'h4001, 16'h4000, 16'h4000, 1'b0);
    reset_mid_image();
    run_image(16'hFFF0, 16'hFFFF, 16'hFFF0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      s   = int'($urandom_range(0, 65535));
      len = int'($urandom_range(1, 600));
      e   = s + len - 1;
      if (e > 65535) e = 65535;
      run_image(s, e, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
